// File: rtl/red_pitaya_daisy_pkg.sv
// Shared encodings for the daisy-chain link: FSM state codes, TX source selects and
// the fixed length of the test-statistics clear phase.
package red_pitaya_daisy_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEnable  = 3'd1,
        StTrain   = 3'd2,
        StTestClr = 3'd3,
        StTest    = 3'd4,
        StLinkUp  = 3'd5,
        StRestart = 3'd6,
        StFail    = 3'd7
    } link_state_e;

    localparam logic [2:0] SEL_OFF   = 3'd0;
    localparam logic [2:0] SEL_USER  = 3'd1;
    localparam logic [2:0] SEL_MAN   = 3'd2;
    localparam logic [2:0] SEL_TRAIN = 3'd3;
    localparam logic [2:0] SEL_LOOP  = 3'd4;
    localparam logic [2:0] SEL_TEST  = 3'd5;

    localparam int unsigned TEST_CLR_LEN = 16;

endpackage

// File: rtl/red_pitaya_sync_bit.sv
// Two-flop single-bit synchronizer with synchronous active-low reset.
module red_pitaya_sync_bit (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/red_pitaya_daisy_link_ctrl.sv
// Daisy-chain link bring-up sequencer: enable, train, optional random-data test, user data.
// Define RP_DAISY_LINK_TEST_EN to include the TEST_CLR/TEST phases and counter evaluation.
module red_pitaya_daisy_link_ctrl import red_pitaya_daisy_pkg::*; #(
    parameter int unsigned EN_DLY    = 1024,
    parameter int unsigned TRAIN_TO  = 1048576,
    parameter int unsigned TEST_LEN  = 65536,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        sys_clk_i,
    input  logic        sys_rstn_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        rx_trained_i,
    input  logic [31:0] tst_err_cnt_i,
    input  logic [31:0] tst_dat_cnt_i,
    output logic        cfg_tx_en_o,
    output logic        cfg_rx_en_o,
    output logic        cfg_rx_train_o,
    output logic [2:0]  cfg_tx_sel_o,
    output logic        cfg_tst_clr_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic        link_up_o,
    output logic        fail_o
);

    localparam logic [23:0] EnLast    = 24'(EN_DLY - 1);
    localparam logic [23:0] TrainLast = 24'(TRAIN_TO - 1);
    localparam logic [7:0]  RetryMax  = 8'(MAX_RETRY);

    link_state_e state_q, state_d;
    logic [23:0] timer_q;
    logic [7:0]  retry_q, retry_d;
    logic        trn_s;
    logic        att_fail;

    logic        tx_en_d, rx_en_d, rx_train_d, link_up_d, fail_d;
    logic [2:0]  tx_sel_d;
    logic        tx_en_q, rx_en_q, rx_train_q, link_up_q, fail_q;
    logic [2:0]  tx_sel_q;

`ifdef RP_DAISY_LINK_TEST_EN
    localparam logic [23:0] ClrLast  = 24'(TEST_CLR_LEN - 1);
    localparam logic [23:0] TestLast = 24'(TEST_LEN - 1);

    logic        eval_q, eval_d;
    logic [2:0]  eval_cnt_q, eval_cnt_d;
    logic [31:0] err_smp_q, dat_smp_q;
    logic        smp_stable;
    logic        tst_clr_d, tst_clr_q;

    assign smp_stable = (tst_err_cnt_i == err_smp_q) && (tst_dat_cnt_i == dat_smp_q);
`else
    logic unused_tst;
    assign unused_tst = ^{tst_err_cnt_i, tst_dat_cnt_i, TEST_LEN};
`endif

    red_pitaya_sync_bit u_sync_trn (
        .clk_i  (sys_clk_i),
        .rstn_i (sys_rstn_i),
        .d_i    (rx_trained_i),
        .q_o    (trn_s)
    );

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        att_fail = 1'b0;
`ifdef RP_DAISY_LINK_TEST_EN
        eval_d     = eval_q;
        eval_cnt_d = eval_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StEnable;
                    retry_d = 8'd0;
                end
            end
            StEnable: begin
                if (timer_q == EnLast) state_d = StTrain;
            end
            StTrain: begin
                if (trn_s) begin
`ifdef RP_DAISY_LINK_TEST_EN
                    state_d = StTestClr;
`else
                    state_d = StLinkUp;
`endif
                end else if (timer_q == TrainLast) begin
                    att_fail = 1'b1;
                end
            end
`ifdef RP_DAISY_LINK_TEST_EN
            StTestClr: begin
                if (timer_q == ClrLast) state_d = StTest;
            end
            StTest: begin
                // Foreign-domain counters are trusted only once two consecutive samples agree.
                if (eval_q) begin
                    eval_cnt_d = eval_cnt_q + 3'd1;
                    if (smp_stable) begin
                        if (tst_err_cnt_i == 32'd0 && tst_dat_cnt_i != 32'd0) begin
                            state_d = StLinkUp;
                        end else begin
                            att_fail = 1'b1;
                        end
                    end else if (eval_cnt_q == 3'd7) begin
                        att_fail = 1'b1;
                    end
                end else if (timer_q == TestLast) begin
                    eval_d     = 1'b1;
                    eval_cnt_d = 3'd1;
                end
            end
`endif
            StLinkUp: begin
                if (!trn_s) att_fail = 1'b1;
            end
            StRestart: begin
                if (timer_q == EnLast) state_d = StEnable;
            end
            StFail: begin
                if (start_i) begin
                    state_d = StEnable;
                    retry_d = 8'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (att_fail) begin
            if (retry_q < RetryMax) begin
                retry_d = retry_q + 8'd1;
                state_d = StRestart;
            end else begin
                state_d = StFail;
            end
        end

        if (stop_i) begin
            state_d = StIdle;
            retry_d = retry_q;
        end

`ifdef RP_DAISY_LINK_TEST_EN
        if (state_d != StTest) eval_d = 1'b0;
`endif
    end

    // Outputs decode the next state so they register on the same edge as state_o.
    always_comb begin
        tx_en_d    = 1'b0;
        rx_en_d    = 1'b0;
        rx_train_d = 1'b0;
        tx_sel_d   = SEL_OFF;
        link_up_d  = 1'b0;
        fail_d     = 1'b0;
`ifdef RP_DAISY_LINK_TEST_EN
        tst_clr_d  = 1'b0;
`endif
        unique case (state_d)
            StEnable: begin
                tx_en_d  = 1'b1;
                rx_en_d  = 1'b1;
                tx_sel_d = SEL_TRAIN;
            end
            StTrain: begin
                tx_en_d    = 1'b1;
                rx_en_d    = 1'b1;
                rx_train_d = 1'b1;
                tx_sel_d   = SEL_TRAIN;
            end
`ifdef RP_DAISY_LINK_TEST_EN
            StTestClr: begin
                tx_en_d   = 1'b1;
                rx_en_d   = 1'b1;
                tst_clr_d = 1'b1;
                tx_sel_d  = SEL_TEST;
            end
            StTest: begin
                tx_en_d  = 1'b1;
                rx_en_d  = 1'b1;
                tx_sel_d = SEL_TEST;
            end
`endif
            StLinkUp: begin
                tx_en_d   = 1'b1;
                rx_en_d   = 1'b1;
                tx_sel_d  = SEL_USER;
                link_up_d = 1'b1;
            end
            StFail:  fail_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state_q    <= StIdle;
            timer_q    <= 24'd0;
            retry_q    <= 8'd0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            rx_train_q <= 1'b0;
            tx_sel_q   <= SEL_OFF;
            link_up_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= (state_d != state_q) ? 24'd0 : timer_q + 24'd1;
            retry_q    <= retry_d;
            tx_en_q    <= tx_en_d;
            rx_en_q    <= rx_en_d;
            rx_train_q <= rx_train_d;
            tx_sel_q   <= tx_sel_d;
            link_up_q  <= link_up_d;
            fail_q     <= fail_d;
        end
    end

`ifdef RP_DAISY_LINK_TEST_EN
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            eval_q     <= 1'b0;
            eval_cnt_q <= 3'd0;
            err_smp_q  <= 32'd0;
            dat_smp_q  <= 32'd0;
            tst_clr_q  <= 1'b0;
        end else begin
            eval_q     <= eval_d;
            eval_cnt_q <= eval_cnt_d;
            err_smp_q  <= tst_err_cnt_i;
            dat_smp_q  <= tst_dat_cnt_i;
            tst_clr_q  <= tst_clr_d;
        end
    end

    assign cfg_tst_clr_o = tst_clr_q;
`else
    assign cfg_tst_clr_o = 1'b0;
`endif

    assign cfg_tx_en_o    = tx_en_q;
    assign cfg_rx_en_o    = rx_en_q;
    assign cfg_rx_train_o = rx_train_q;
    assign cfg_tx_sel_o   = tx_sel_q;
    assign state_o        = state_q;
    assign retry_cnt_o    = retry_q;
    assign link_up_o      = link_up_q;
    assign fail_o         = fail_q;

endmodule

// File: doc/red_pitaya_daisy_link_ctrl.md
# red_pitaya_daisy_link_ctrl

Link bring-up sequencer for the daisy-chain serial link, running in the system-bus clock domain. It drives the daisy block's TX/RX enables, the RX training request, the TX data-source select and the test-statistics clear. It steps the link through enable, training, an optional random-data test and user-data mode. Failed attempts are retried a bounded number of times and outcomes are reported on status outputs for the register map.

## Interface
Parameters:
- EN_DLY, 1024: cycles to wait after enabling TX/RX (and after disabling on restart) before the next step.
- TRAIN_TO, 1048576: training timeout in cycles.
- TEST_LEN, 65536: random-data test duration in cycles.
- MAX_RETRY, 3: retries after the first attempt before declaring failure.
- All timing parameters are < 2^24.

Ports:
- sys_clk_i  in  1  bus clock; the only clock.
- sys_rstn_i  in  1  reset; synchronous, active-low.
- start_i  in  1  single-cycle pulse; start bring-up.
- stop_i  in  1  single-cycle pulse; abort to IDLE.
- rx_trained_i  in  1  RX trained flag; asynchronous (RX serial domain).
- tst_err_cnt_i  in  32  test error count; foreign domain.
- tst_dat_cnt_i  in  32  test data count; foreign domain.
- cfg_tx_en_o  out  1  TX enable.
- cfg_rx_en_o  out  1  RX enable.
- cfg_rx_train_o  out  1  RX training request.
- cfg_tx_sel_o  out  3  TX source: 0 idle, 1 user data, 3 training, 5 test.
- cfg_tst_clr_o  out  1  test-statistics clear.
- state_o  out  3  current state code.
- retry_cnt_o  out  8  retries used in the current run.
- link_up_o  out  1  high in LINK_UP.
- fail_o  out  1  high in FAIL.

## Operation
- rx_trained_i passes through a 2-flop synchronizer (trn_s). Only trn_s is used.
- One 24-bit timer clears on every state entry and increments every cycle.
- The "attempt failed" action is:
  - if retry_cnt < MAX_RETRY: retry_cnt+1, go to RESTART;
  - otherwise: go to FAIL.
- States (code) and the outputs each one drives:
  - IDLE (0): all config outputs 0.
    - start_i: retry_cnt=0, go to ENABLE.
  - ENABLE (1): tx_en=1, rx_en=1, tx_sel=3.
    - timer==EN_DLY-1: go to TRAIN.
  - TRAIN (2): tx_en=1, rx_en=1, rx_train=1, tx_sel=3.
    - trn_s=1: go to TEST_CLR (LINK_UP without the macro).
    - else timer==TRAIN_TO-1: attempt failed.
  - TEST_CLR (3): tx_en=1, rx_en=1, tst_clr=1, tx_sel=5.
    - held 16 cycles, then go to TEST.
  - TEST (4): tx_en=1, rx_en=1, tx_sel=5.
    - timer==TEST_LEN-1: start the evaluation window.
    - Evaluation window: sample both counters each cycle until two consecutive samples are identical, bounded at 8 cycles.
    - Pass when the stable err==0 and dat!=0: go to LINK_UP.
    - Non-zero err, dat==0 or no stable pair within 8 cycles: attempt failed.
  - LINK_UP (5): tx_en=1, rx_en=1, tx_sel=1, link_up_o=1.
    - trn_s=0: attempt failed (link loss).
  - RESTART (6): all config outputs 0.
    - timer==EN_DLY-1: go to ENABLE.
  - FAIL (7): all config outputs 0, fail_o=1.
    - Sticky until start_i (retry_cnt=0, go to ENABLE) or stop_i.
- stop_i in any state goes to IDLE next cycle. stop_i wins over start_i and over every other transition.
- start_i is ignored outside IDLE and FAIL.
- retry_cnt is held in IDLE, LINK_UP and FAIL, so software can read it.

## Timing
- Reset: state IDLE; every output 0, including cfg_tx_sel_o=0 and retry_cnt_o=0. Timer and synchronizer are cleared.
- All outputs are registered and decoded from the next state, so they change on the same edge as state_o.
- start_i in IDLE: cfg_tx_en_o=1 on the next edge.
- rx_trained_i to action: 2 cycles of synchronization, then the transition on the following edge.
- ENABLE lasts exactly EN_DLY cycles; TEST_CLR exactly 16; RESTART exactly EN_DLY.
- TRAIN times out after exactly TRAIN_TO cycles.
- A trained flag in the same cycle as the timeout counts as success.
- Reset asserted mid-run returns to IDLE on that edge, with no intermediate output states.

## Configuration
- RP_DAISY_LINK_TEST_EN defined: TEST_CLR and TEST states are present; success in TRAIN goes to TEST_CLR.
- Not defined: TEST_CLR, TEST and the counter-sampling logic are removed. TRAIN success goes directly to LINK_UP, cfg_tst_clr_o is tied 0, and tst_*_i are unused.
- State codes are unchanged either way.

## Structure
- Shared package `red_pitaya_daisy_pkg`:
  - state encoding (IDLE..FAIL, 3 bits);
  - TX-select constants (SEL_OFF=0, SEL_USER=1, SEL_MAN=2, SEL_TRAIN=3, SEL_LOOP=4, SEL_TEST=5);
  - TEST_CLR length constant (16).
- One sub-module: `red_pitaya_sync_bit`, a 2-flop single-bit synchronizer with synchronous active-low reset.

## Test plan
- Basic bring-up with EN_DLY=4, TRAIN_TO=64, TEST_LEN=32 and the macro defined. Pulse start, raise rx_trained at cycle 10, hold err=0, dat=500. Expect ENABLE for 4 cycles, TRAIN, TEST_CLR with tst_clr=1 for 16 cycles, TEST, then LINK_UP with tx_sel=1, link_up_o=1 and retry_cnt_o=0.
- rx_trained held low with MAX_RETRY=2. Expect three TRAIN timeouts of 64 cycles each, separated by RESTART periods of 4 cycles with tx_en=0. End in FAIL with fail_o=1, retry_cnt_o=2 and every config output 0.
- Test-phase error: err=3 at the end of TEST. Expect RESTART and retry_cnt_o=1. Set err=0 on the second attempt and expect LINK_UP with retry_cnt_o=1.
- Link loss: in LINK_UP, drop rx_trained. Expect RESTART exactly 3 cycles later.
- Control priority: stop_i and start_i together in TRAIN give IDLE with all outputs 0 on the next edge. Reset asserted in TEST gives IDLE with all outputs 0.
- Macro undefined: trained goes straight to LINK_UP, cfg_tst_clr_o never asserts, and state_o never shows 3 or 4.
